// File: rtl/patgen.sv
// ============================================================================
// Module  : patgen
// Purpose : Test-pattern pixel source that follows the display sync generator.
//           It produces DE plus RGB one DCLK after preDE.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module patgen #(
    parameter int COLW      = 8,
    parameter int GRID_LOG2 = 5
) (
    input  logic            DCLK,
    input  logic            DRST,
    input  logic [1:0]      RESOL,
    input  logic [1:0]      PSEL,
    input  logic            VRSTART,
    input  logic            DSP_HSYNC_X,
    input  logic            DSP_VSYNC_X,
    input  logic            DSP_preDE,
    output logic            DSP_DE,
    output logic [COLW-1:0] DSP_R,
    output logic [COLW-1:0] DSP_G,
    output logic [COLW-1:0] DSP_B
);

    logic [10:0]     hpos;
    logic [10:0]     vpos;
    logic [7:0]      fcnt;
    logic [1:0]      psel_l;
    logic [1:0]      res_l;
    logic            vrst_l;
    logic            vsync_d;
    logic            prede_d;

    logic            frame_start;
    logic            line_end;
    logic            de_next;
    logic [10:0]     hdo;
    logic [10:0]     vdo;
    logic [10:0]     barw;
    logic [10:0]     thr;
    logic [2:0]      bar_idx;
    logic            grid_on;
    logic [COLW-1:0] pix_r;
    logic [COLW-1:0] pix_g;
    logic [COLW-1:0] pix_b;

    // HSYNC is forwarded to the panel outside this block; nothing here needs it.
    logic unused_hsync;
    assign unused_hsync = DSP_HSYNC_X;

    assign frame_start = vsync_d & ~DSP_VSYNC_X;
    assign line_end    = prede_d & ~DSP_preDE;
    assign de_next     = DSP_preDE & vrst_l;

    always_comb begin
        hdo  = 11'd640;
        vdo  = 11'd480;
        barw = 11'd80;
        case (res_l)
            2'd1:    begin hdo = 11'd800;  vdo = 11'd600;  barw = 11'd100; end
            2'd2:    begin hdo = 11'd1024; vdo = 11'd768;  barw = 11'd128; end
            2'd3:    begin hdo = 11'd1280; vdo = 11'd1024; barw = 11'd160; end
            default: begin hdo = 11'd640;  vdo = 11'd480;  barw = 11'd80;  end
        endcase
    end

    // Bar index = number of bar boundaries already passed; saturates at 7 by construction.
    always_comb begin
        bar_idx = 3'd0;
        thr     = barw;
        for (int k = 1; k < 8; k++) begin
            if (hpos >= thr) begin
                bar_idx = bar_idx + 3'd1;
            end
            thr = thr + barw;
        end
    end

    assign grid_on = (hpos[GRID_LOG2-1:0] == '0) || (vpos[GRID_LOG2-1:0] == '0) ||
                     (hpos == hdo - 11'd1)       || (vpos == vdo - 11'd1);

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (psel_l)
            // Bar order white..black maps to inverted index bits: R=~b1, G=~b2, B=~b0.
            2'd0: begin
                pix_r = {COLW{~bar_idx[1]}};
                pix_g = {COLW{~bar_idx[2]}};
                pix_b = {COLW{~bar_idx[0]}};
            end
            2'd1: begin
                pix_r = {COLW{grid_on}};
                pix_g = {COLW{grid_on}};
                pix_b = {COLW{grid_on}};
            end
            2'd2: begin
                pix_r = hpos[COLW-1:0];
                pix_g = hpos[COLW-1:0];
                pix_b = hpos[COLW-1:0];
            end
            default: begin
                pix_r = hpos[COLW-1:0] + COLW'(fcnt);
                pix_g = vpos[COLW-1:0];
                pix_b = COLW'(fcnt);
            end
        endcase
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            hpos    <= '0;
            vpos    <= '0;
            fcnt    <= '0;
            psel_l  <= '0;
            res_l   <= '0;
            vrst_l  <= 1'b0;
            vsync_d <= 1'b1;
            prede_d <= 1'b0;
            DSP_DE  <= 1'b0;
            DSP_R   <= '0;
            DSP_G   <= '0;
            DSP_B   <= '0;
        end else begin
            vsync_d <= DSP_VSYNC_X;
            prede_d <= DSP_preDE;
            hpos    <= DSP_preDE ? hpos + 11'd1 : 11'd0;
            // Mode, resolution and enable only change here, so a frame is never torn.
            if (frame_start) begin
                psel_l <= PSEL;
                res_l  <= RESOL;
                vrst_l <= VRSTART;
                vpos   <= '0;
                fcnt   <= fcnt + 8'd1;
            end else if (line_end) begin
                vpos   <= vpos + 11'd1;
            end
            DSP_DE <= de_next;
            DSP_R  <= de_next ? pix_r : '0;
            DSP_G  <= de_next ? pix_g : '0;
            DSP_B  <= de_next ? pix_b : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_patgen.sv
// ============================================================================
// Module  : tb_patgen
// Purpose : Directed self-checking bench for patgen with a small pixel model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_patgen;

    logic       DCLK = 1'b0;
    logic       DRST;
    logic [1:0] RESOL;
    logic [1:0] PSEL;
    logic       VRSTART;
    logic       DSP_HSYNC_X;
    logic       DSP_VSYNC_X;
    logic       DSP_preDE;
    logic       DSP_DE;
    logic [7:0] DSP_R;
    logic [7:0] DSP_G;
    logic [7:0] DSP_B;

    int checks   = 0;
    int failures = 0;

    // Reference state tracked by the bench
    int         fm;
    int         vline;
    bit         en_m;
    logic [1:0] mode_m;
    logic [1:0] res_m;
    logic [23:0] cap [0:2047];

    patgen #(.COLW(8), .GRID_LOG2(5)) dut (
        .DCLK        (DCLK),
        .DRST        (DRST),
        .RESOL       (RESOL),
        .PSEL        (PSEL),
        .VRSTART     (VRSTART),
        .DSP_HSYNC_X (DSP_HSYNC_X),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .DSP_preDE   (DSP_preDE),
        .DSP_DE      (DSP_DE),
        .DSP_R       (DSP_R),
        .DSP_G       (DSP_G),
        .DSP_B       (DSP_B)
    );

    always #5 DCLK = ~DCLK;

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int h, input int v);
        int hdo;
        int vdo;
        int idx;
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (res_m)
            2'd0:    begin hdo = 640;  vdo = 480;  end
            2'd1:    begin hdo = 800;  vdo = 600;  end
            2'd2:    begin hdo = 1024; vdo = 768;  end
            default: begin hdo = 1280; vdo = 1024; end
        endcase
        case (mode_m)
            2'd0: begin
                idx = h / (hdo / 8);
                if (idx > 7) idx = 7;
                return bars[idx];
            end
            2'd1: return ((h % 32 == 0) || (v % 32 == 0) || (h == hdo - 1) || (v == vdo - 1))
                         ? 24'hFFFFFF : 24'h000000;
            2'd2: return {8'(h), 8'(h), 8'(h)};
            default: return {8'((h + fm) % 256), 8'(v), 8'(fm)};
        endcase
    endfunction

    // One active line of w pixels followed by blanking with an HSYNC pulse.
    task automatic line(input int w);
        for (int i = 0; i < w; i++) begin
            DSP_preDE = 1'b1;
            tick();
            cap[i] = {DSP_R, DSP_G, DSP_B};
            chk($sformatf("pix x=%0d y=%0d", i, vline), {DSP_DE, DSP_R, DSP_G, DSP_B},
                en_m ? {1'b1, exp_rgb(i, vline)} : 25'd0);
        end
        DSP_preDE = 1'b0;
        tick();
        chk($sformatf("line_end y=%0d", vline), {DSP_DE, DSP_R, DSP_G, DSP_B}, 25'd0);
        DSP_HSYNC_X = 1'b0;
        tick();
        DSP_HSYNC_X = 1'b1;
        tick();
        vline++;
    endtask

    task automatic vs_pulse();
        DSP_VSYNC_X = 1'b0;
        tick();
        mode_m = PSEL;
        res_m  = RESOL;
        en_m   = VRSTART;
        vline  = 0;
        fm     = (fm + 1) % 256;
        tick();
        DSP_VSYNC_X = 1'b1;
        tick();
    endtask

    task automatic hc(input string tag, input int x, input logic [23:0] exp);
        chk(tag, {8'd0, cap[x]}, {8'd0, exp});
    endtask

    initial begin
        DRST = 1'b1; RESOL = 2'd0; PSEL = 2'd0; VRSTART = 1'b1;
        DSP_HSYNC_X = 1'b1; DSP_VSYNC_X = 1'b1; DSP_preDE = 1'b0;
        fm = 0; vline = 0; en_m = 1'b0; mode_m = 2'd0; res_m = 2'd0;
        tick(); tick();
        chk("reset_out", {DSP_DE, DSP_R, DSP_G, DSP_B}, 25'd0);
        DRST = 1'b0;

        // Blank before the first frame start even though VRSTART=1
        line(16);

        // Frame 1: colour bars at 640 wide, line runs past HDO to hit the clamp
        vs_pulse();
        line(700);
        hc("bar0_x0",    0, 24'hFFFFFF);
        hc("bar0_x79",  79, 24'hFFFFFF);
        hc("bar1_x80",  80, 24'hFFFF00);
        hc("bar2_x160", 160, 24'h00FFFF);
        hc("bar3_x240", 240, 24'h00FF00);
        hc("bar4_x320", 320, 24'hFF00FF);
        hc("bar5_x400", 400, 24'hFF0000);
        hc("bar6_x559", 559, 24'h0000FF);
        hc("bar7_x560", 560, 24'h000000);
        hc("bar_clamp_x690", 690, 24'h000000);
        PSEL = 2'd2;
        line(640);
        hc("bars_persist_x300", 300, 24'h00FF00);

        // Frame 2: grey ramp takes effect
        vs_pulse();
        line(640);
        hc("grey_x300", 300, 24'h2C2C2C);
        hc("grey_x256", 256, 24'h000000);
        hc("grey_x255", 255, 24'hFFFFFF);

        // Frame 3: bars at 1280 wide
        RESOL = 2'd3; PSEL = 2'd0;
        vs_pulse();
        line(1280);
        hc("bar1280_x159", 159, 24'hFFFFFF);
        hc("bar1280_x160", 160, 24'hFFFF00);
        hc("bar1280_x1119", 1119, 24'h0000FF);
        hc("bar1280_x1120", 1120, 24'h000000);

        // Frame 4: grid at 640x480, full-width lines only where the edges matter
        RESOL = 2'd0; PSEL = 2'd1;
        vs_pulse();
        for (int v = 0; v < 480; v++) begin
            line((v == 0 || v == 1 || v == 31 || v == 32 || v == 479) ? 640 : 40);
            if (v == 1) begin
                hc("grid_y1_x0",   0,   24'hFFFFFF);
                hc("grid_y1_x1",   1,   24'h000000);
                hc("grid_y1_x32",  32,  24'hFFFFFF);
                hc("grid_y1_x608", 608, 24'hFFFFFF);
                hc("grid_y1_x638", 638, 24'h000000);
                hc("grid_y1_x639", 639, 24'hFFFFFF);
            end
            if (v == 31)  hc("grid_y31_x100",  100, 24'h000000);
            if (v == 32)  hc("grid_y32_x100",  100, 24'hFFFFFF);
            if (v == 479) hc("grid_y479_x100", 100, 24'hFFFFFF);
        end

        // Frames 5..7: scroll pattern tracks the frame count
        PSEL = 2'd3;
        vs_pulse();
        line(4);
        hc("scroll_f5_y0_x0", 0, 24'h050005);
        line(4);
        hc("scroll_f5_y1_x2", 2, 24'h070105);
        vs_pulse();
        line(4);
        hc("scroll_f6_x0", 0, 24'h060006);
        vs_pulse();
        line(4);
        hc("scroll_f7_x0", 0, 24'h070007);

        // Run the frame counter up to 255 and across the wrap
        for (int k = 0; k < 248; k++) vs_pulse();
        line(2);
        hc("scroll_f255_x0", 0, 24'hFF00FF);
        hc("scroll_f255_x1", 1, 24'h0000FF);
        vs_pulse();
        line(2);
        hc("scroll_wrap_x0", 0, 24'h000000);
        hc("scroll_wrap_x1", 1, 24'h010000);

        // Display disabled for a frame
        VRSTART = 1'b0;
        vs_pulse();
        line(8);

        // Reset in the middle of an active line
        VRSTART = 1'b1;
        vs_pulse();
        for (int i = 0; i < 10; i++) begin
            DSP_preDE = 1'b1;
            tick();
        end
        DRST = 1'b1;
        tick();
        chk("rst_mid_line", {DSP_DE, DSP_R, DSP_G, DSP_B}, 25'd0);
        DRST = 1'b0;
        en_m = 1'b0; fm = 0; mode_m = 2'd0; res_m = 2'd0;
        tick();
        chk("blank_after_rst", {DSP_DE, DSP_R, DSP_G, DSP_B}, 25'd0);
        DSP_preDE = 1'b0;
        tick();
        line(20);
        vs_pulse();
        line(4);
        hc("post_rst_fcnt_x0", 0, 24'h010001);
        hc("post_rst_fcnt_x3", 3, 24'h040001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
